// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush control, a valid bit
// and saturating stall/flush performance counters.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcAD,
    input  logic                      ALUSrcBD,
    input  logic                      LdSrcD,
    input  logic                      StSrcD,
    input  logic                      JalSrcD,
    input  logic [1:0]                ResultSrcD,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
    input  logic [2:0]                ImmSrcD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PC_PlusD,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcAE,
    output logic                      ALUSrcBE,
    output logic                      LdSrcE,
    output logic                      StSrcE,
    output logic                      JalSrcE,
    output logic [1:0]                ResultSrcE,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
    output logic [2:0]                ImmSrcE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PC_PlusE,
    output logic                      ValidE,
    output logic [CNT_WIDTH-1:0]      StallCnt,
    output logic [CNT_WIDTH-1:0]      FlushCnt
);

    // All stage fields travel as one packed word so load/hold/bubble apply uniformly.
    localparam int STAGE_W = 14 + ALU_CTRL_WIDTH + 5 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [STAGE_W-1:0]   stage_d, stage_q, stage_in;
    logic                 valid_d, valid_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;

    assign stage_in = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD,
                       LdSrcD, StSrcD, JalSrcD, ResultSrcD, ALUControlD, ImmSrcD,
                       RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD, PCD, PC_PlusD};

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        stage_d     = stage_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (FlushE) begin
            stage_d = '0;
            valid_d = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (StallE) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stage_d = stage_in;
            valid_d = ValidD;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            stage_q     <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE,
            LdSrcE, StSrcE, JalSrcE, ResultSrcE, ALUControlE, ImmSrcE,
            RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PC_PlusE} = stage_q;

    assign ValidE   = valid_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: table of load/stall/flush/reset vectors,
// plus hand sequences for PC hold, reset mid-stall and counter saturation.
module tb_id_ex_pipe_reg;

    localparam int W = 193;
    // Bit offsets of fields inside the packed stage word (LSB first).
    localparam int PCP_LO  = 0;
    localparam int PC_LO   = 32;
    localparam int RD_LO   = 96;
    localparam int RD1_LO  = 143;
    localparam int ALUC_LO = 178;
    localparam int MEMW_B  = 191;
    localparam int REGW_B  = 192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, StallE, FlushE, ValidD;
    logic [W-1:0] d_bus;
    logic [W-1:0] e_bus;
    logic [W-1:0] sm_bus;

    logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD, LdSrcD, StSrcD, JalSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  ImmSrcD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PC_PlusD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    assign {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD, LdSrcD, StSrcD,
            JalSrcD, ResultSrcD, ALUControlD, ImmSrcD, RD1D, RD2D, Rs1D, Rs2D, RdD,
            ImmExtD, PCD, PC_PlusD} = d_bus;

    logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, LdSrcE, StSrcE, JalSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  ImmSrcE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PC_PlusE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, sm_valid;
    logic [15:0] StallCnt, FlushCnt;
    logic [3:0]  sm_stall_cnt, sm_flush_cnt;

    assign e_bus = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, LdSrcE, StSrcE,
                    JalSrcE, ResultSrcE, ALUControlE, ImmSrcE, RD1E, RD2E, Rs1E, Rs2E, RdE,
                    ImmExtE, PCE, PC_PlusE};

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .LdSrcD(LdSrcD), .StSrcD(StSrcD),
        .JalSrcD(JalSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .ImmSrcD(ImmSrcD), .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ImmExtD(ImmExtD), .PCD(PCD), .PC_PlusD(PC_PlusD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .LdSrcE(LdSrcE), .StSrcE(StSrcE),
        .JalSrcE(JalSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .ImmSrcE(ImmSrcE), .RD1E(RD1E), .RD2E(RD2E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ImmExtE(ImmExtE), .PCE(PCE), .PC_PlusE(PC_PlusE),
        .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    // Narrow-counter instance for saturation checks; shares all inputs.
    id_ex_pipe_reg #(.CNT_WIDTH(4)) dut_sm (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .LdSrcD(LdSrcD), .StSrcD(StSrcD),
        .JalSrcD(JalSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .ImmSrcD(ImmSrcD), .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ImmExtD(ImmExtD), .PCD(PCD), .PC_PlusD(PC_PlusD),
        .RegWriteE(sm_bus[192]), .MemWriteE(sm_bus[191]), .JumpE(sm_bus[190]),
        .BranchE(sm_bus[189]), .ALUSrcAE(sm_bus[188]), .ALUSrcBE(sm_bus[187]),
        .LdSrcE(sm_bus[186]), .StSrcE(sm_bus[185]), .JalSrcE(sm_bus[184]),
        .ResultSrcE(sm_bus[183:182]), .ALUControlE(sm_bus[181:178]),
        .ImmSrcE(sm_bus[177:175]), .RD1E(sm_bus[174:143]), .RD2E(sm_bus[142:111]),
        .Rs1E(sm_bus[110:106]), .Rs2E(sm_bus[105:101]), .RdE(sm_bus[100:96]),
        .ImmExtE(sm_bus[95:64]), .PCE(sm_bus[63:32]), .PC_PlusE(sm_bus[31:0]),
        .ValidE(sm_valid), .StallCnt(sm_stall_cnt), .FlushCnt(sm_flush_cnt)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Every field is a distinct linear function of the tag; tag 0 gives an all-zero word.
    function automatic logic [W-1:0] mk(input logic [15:0] t);
        logic [31:0] rd1, rd2, imm, pc, pcp;
        rd1 = {t, t};
        rd2 = {t[7:0], t[15:8], t[7:0], t[15:8]};
        imm = {4'h0, t[11:0], t};
        pc  = {14'h0, t, 2'b00};
        pcp = {t[15:8], 8'h00, t[7:0], 8'h00};
        return {t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7], t[8], t[10:9], t[14:11],
                t[15:13], rd1, rd2, t[4:0], t[9:5], t[14:10], imm, pc, pcp};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic f, input logic v,
                         input logic [W-1:0] bus);
        rst = r; StallE = s; FlushE = f; ValidD = v; d_bus = bus;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [15:0] tag, exp_tag;
        logic        exp_valid;
        logic [15:0] exp_scnt, exp_fcnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 0, 0, 1, 16'h5A5A, 16'h0000, 0, 0, 0};  // reset with busy inputs
        vecs[1]  = '{0, 0, 0, 1, 16'h1111, 16'h1111, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 16'h2222, 16'h2222, 0, 0, 0};  // invalid still loads
        vecs[3]  = '{0, 1, 0, 1, 16'h3333, 16'h2222, 0, 1, 0};
        vecs[4]  = '{0, 1, 0, 1, 16'h4444, 16'h2222, 0, 2, 0};
        vecs[5]  = '{0, 0, 0, 1, 16'h5555, 16'h5555, 1, 2, 0};
        vecs[6]  = '{0, 0, 1, 1, 16'h6666, 16'h0000, 0, 2, 1};
        vecs[7]  = '{0, 1, 1, 1, 16'hFFFF, 16'h0000, 0, 2, 2};  // flush beats stall
        vecs[8]  = '{0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 2, 2};
        vecs[9]  = '{0, 1, 0, 0, 16'h0F0F, 16'hFFFF, 1, 3, 2};
        vecs[10] = '{1, 1, 0, 1, 16'h1234, 16'h0000, 0, 0, 0};  // reset beats stall
        vecs[11] = '{0, 0, 0, 1, 16'hA5C3, 16'hA5C3, 1, 0, 0};

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].valid, mk(vecs[i].tag));
            check($sformatf("v%0d fields", i), e_bus, mk(vecs[i].exp_tag));
            check($sformatf("v%0d valid", i), W'(ValidE), W'(vecs[i].exp_valid));
            check($sformatf("v%0d stall_cnt", i), W'(StallCnt), W'(vecs[i].exp_scnt));
            check($sformatf("v%0d flush_cnt", i), W'(FlushCnt), W'(vecs[i].exp_fcnt));
        end

        // Specific load: 0xDEADBEEF / rd 5 / regwrite / alu 0110, visible one edge later.
        apply(1, 0, 0, 0, '0);
        d_bus = '0;
        d_bus[RD1_LO +: 32]  = 32'hDEADBEEF;
        d_bus[RD_LO +: 5]    = 5'd5;
        d_bus[REGW_B]        = 1'b1;
        d_bus[ALUC_LO +: 4]  = 4'b0110;
        apply(0, 0, 0, 1, d_bus);
        check("load rd1", W'(RD1E), W'(32'hDEADBEEF));
        check("load rd", W'(RdE), W'(5'd5));
        check("load regwrite", W'(RegWriteE), W'(1'b1));
        check("load aluctrl", W'(ALUControlE), W'(4'b0110));
        check("load valid", W'(ValidE), W'(1'b1));

        // PC hold across a 3-cycle stall, then release.
        apply(1, 0, 0, 0, '0);
        d_bus = '0;
        d_bus[PC_LO +: 32] = 32'h100;
        apply(0, 0, 0, 1, d_bus);
        for (int k = 1; k <= 3; k++) begin
            d_bus[PC_LO +: 32] = 32'h100 + 32'(4 * k);
            apply(0, 1, 0, 1, d_bus);
            check($sformatf("stall%0d pc", k), W'(PCE), W'(32'h100));
        end
        check("stall cnt3", W'(StallCnt), W'(16'd3));
        apply(0, 0, 0, 1, d_bus);
        check("release pc", W'(PCE), W'(32'h10C));

        // Flush+stall bubble with write enables asserted on D.
        d_bus = mk(16'h0000);
        d_bus[REGW_B] = 1'b1;
        d_bus[MEMW_B] = 1'b1;
        d_bus[RD_LO +: 5] = 5'd9;
        apply(0, 1, 1, 1, d_bus);
        check("bubble regwrite", W'(RegWriteE), '0);
        check("bubble memwrite", W'(MemWriteE), '0);
        check("bubble rd", W'(RdE), '0);
        check("bubble valid", W'(ValidE), '0);
        check("bubble flush_cnt", W'(FlushCnt), W'(16'd1));
        check("bubble stall_cnt", W'(StallCnt), W'(16'd3));

        // Reset in the middle of a stall run.
        apply(1, 0, 0, 0, '0);
        apply(0, 0, 0, 1, mk(16'h7777));
        for (int k = 0; k < 7; k++) apply(0, 1, 0, 1, mk(16'h0101));
        check("mid stall_cnt", W'(StallCnt), W'(16'd7));
        check("mid fields", e_bus, mk(16'h7777));
        apply(1, 1, 0, 1, mk(16'h0101));
        check("mid rst fields", e_bus, '0);
        check("mid rst stall_cnt", W'(StallCnt), '0);
        check("mid rst valid", W'(ValidE), '0);
        apply(0, 0, 0, 1, mk(16'h1357));
        check("post rst fields", e_bus, mk(16'h1357));
        check("post rst valid", W'(ValidE), W'(1'b1));

        // Saturation on the 4-bit counter instance.
        apply(1, 0, 0, 0, '0);
        for (int k = 1; k <= 20; k++) begin
            apply(0, 1, 0, 1, mk(16'h00FF));
            if (k == 14 || k == 15 || k == 20)
                check($sformatf("sat stall k%0d", k), W'(sm_stall_cnt), W'(k > 15 ? 15 : k));
        end
        check("sat wide stall", W'(StallCnt), W'(16'd20));
        for (int k = 1; k <= 18; k++) apply(0, 1, 1, 1, mk(16'h00FF));
        check("sat flush", W'(sm_flush_cnt), W'(4'd15));
        check("sat stall held", W'(sm_stall_cnt), W'(4'd15));
        check("sat fields", sm_bus, '0);
        check("sat valid", W'(sm_valid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
